// File: rtl/dm_lsu_pkg.sv
// Shared definitions for the dm_lsu load/store unit: op codes, FSM state
// encodings, access sizes and small op-decode helpers.
// Optional build macro: DM_LSU_MISALIGN_TRAP_EN (used by dm_lsu_master).
package dm_lsu_pkg;

  // Request op codes as presented on req_op.
  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  // FSM state encodings.
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RMW_RD = 2'd1;
  localparam logic [1:0] RMW_WR = 2'd2;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  function automatic logic is_load(input logic [2:0] op);
    return (op <= OP_LBU);
  endfunction

  function automatic logic is_store(input logic [2:0] op);
    return (op >= OP_SW);
  endfunction

  function automatic size_e access_size(input logic [2:0] op);
    size_e sz;
    case (op)
      OP_LW, OP_SW:          sz = SZ_WORD;
      OP_LH, OP_LHU, OP_SH:  sz = SZ_HALF;
      default:               sz = SZ_BYTE;
    endcase
    return sz;
  endfunction

  // True when the byte offset does not match the natural alignment of the op.
  function automatic logic is_misaligned(input logic [2:0] op,
                                         input logic [1:0] byte_off);
    logic mis;
    case (access_size(op))
      SZ_WORD: mis = (byte_off != 2'b00);
      SZ_HALF: mis = byte_off[0];
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dm_lsu_lane.sv
// Combinational lane logic for dm_lsu_master: extracts and sign/zero-extends
// the addressed byte or halfword of a read word for loads, and builds the
// merged word for sub-word stores (target lane replaced, others kept).
// Halfword lanes are chosen by byte_off[1] only, so an unaligned halfword
// offset is implicitly aligned down.
module dm_lsu_lane
  import dm_lsu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  byte_off,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [4:0]  bit_sel;
  logic [7:0]  byte_val;
  logic [15:0] half_val;

  assign bit_sel  = {byte_off, 3'b000};
  assign byte_val = rdata[bit_sel +: 8];
  assign half_val = byte_off[1] ? rdata[31:16] : rdata[15:0];

  // Load extraction with sign or zero extension per op.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
    load_data = rdata;
    case (access_size(op))
      SZ_HALF: load_data = (op == OP_LH) ? {{16{half_val[15]}}, half_val}
                                         : {16'h0000, half_val};
      SZ_BYTE: load_data = (op == OP_LB) ? {{24{byte_val[7]}}, byte_val}
                                         : {24'h000000, byte_val};
      default: load_data = rdata;
    endcase
  end

  // Store merge: replace only the addressed lane of the read word.
  always_comb begin
    merge_data = rdata;
    case (access_size(op))
      SZ_HALF: begin
        if (byte_off[1]) merge_data[31:16] = wdata[15:0];
        else             merge_data[15:0]  = wdata[15:0];
      end
      SZ_BYTE: merge_data[bit_sel +: 8] = wdata[7:0];
      default: merge_data = wdata;
    endcase
  end

endmodule

// File: rtl/dm_lsu_master.sv
// Load/store unit (MEM stage) driving a word-wide data memory that has a
// combinational read and a single-enable posedge write, no byte enables.
// Loads and sw complete in one accept cycle; sh/sb run a registered
// read-modify-write sequence IDLE -> RMW_RD -> RMW_WR -> IDLE.
// Optional build macro: DM_LSU_MISALIGN_TRAP_EN -- when defined, misaligned
// word/halfword accesses are rejected with resp_err; otherwise they are
// silently aligned down.
module dm_lsu_master
  import dm_lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = 3072,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [31:0]       req_pc,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  output logic              resp_err,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  output logic              dm_we,
  output logic [31:0]       dm_pc,
  input  logic [31:0]       dm_rdata
);

  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(DEPTH_WORDS * 4);

  logic [1:0]        state;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       pc_q;
  logic [31:0]       merge_q;

  logic        accept;
  logic        out_of_range;
  logic        misaligned;
  logic        addr_bad;
  logic        is_idle;
  logic [2:0]  lane_op;
  logic [1:0]  lane_off;
  logic [31:0] lane_wdata;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  assign is_idle      = (state == IDLE);
  assign req_ready    = is_idle;
  assign accept       = req_valid && is_idle;
  assign out_of_range = (req_addr >= ADDR_LIMIT);

`ifdef DM_LSU_MISALIGN_TRAP_EN
  assign misaligned = is_misaligned(req_op, req_addr[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  assign addr_bad = out_of_range || misaligned;

  // The lane unit serves the live request in IDLE and the latched store in RMW.
  assign lane_op    = is_idle ? req_op          : op_q;
  assign lane_off   = is_idle ? req_addr[1:0]   : addr_q[1:0];
  assign lane_wdata = is_idle ? req_wdata       : wdata_q;

  dm_lsu_lane u_lane (
    .op         (lane_op),
    .byte_off   (lane_off),
    .rdata      (dm_rdata),
    .wdata      (lane_wdata),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  // Memory-side outputs: live request in IDLE, latched request during RMW.
  always_comb begin
    dm_addr  = {req_addr[ADDR_W-1:2], 2'b00};
    dm_pc    = req_pc;
    dm_wdata = req_wdata;
    if (!is_idle) begin
      dm_addr = {addr_q[ADDR_W-1:2], 2'b00};
      dm_pc   = pc_q;
    end
    if (state == RMW_WR) dm_wdata = merge_q;
  end

  // Write enable only on a good sw accept or in RMW_WR; reset masks it
  // combinationally so an abandoned RMW never reaches the memory.
  assign dm_we = !reset &&
                 ((accept && (req_op == OP_SW) && !addr_bad) || (state == RMW_WR));

  // FSM, request latches, merge register and registered response.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state      <= IDLE;
      op_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      pc_q       <= '0;
      merge_q    <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (addr_bad) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else if (is_load(req_op)) begin
              resp_valid <= 1'b1;
              resp_data  <= load_data;
            end else if (req_op == OP_SW) begin
              resp_valid <= 1'b1;
            end else begin
              op_q    <= req_op;
              addr_q  <= req_addr;
              wdata_q <= req_wdata;
              pc_q    <= req_pc;
              state   <= RMW_RD;
            end
          end
        end
        RMW_RD: begin
          merge_q <= merge_data;
          state   <= RMW_WR;
        end
        RMW_WR: begin
          resp_valid <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_lsu_master.sv
// Scoreboard bench for dm_lsu_master with a behavioural word memory.
// Stimulus pushes expected responses into a queue; a negedge monitor pops
// and compares whenever resp_valid is seen.
module tb_dm_lsu_master;
  import dm_lsu_pkg::*;

  localparam int DEPTH = 3072;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [31:0] req_pc = '0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_we;
  logic [31:0] dm_pc;
  logic [31:0] dm_rdata;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [31:0] mem [0:DEPTH-1];
  logic        pl_en = 1'b0;
  int          pl_idx = 0;
  logic [31:0] pl_data = '0;
  int          rd_idx;

  always #5 clk = ~clk;

  dm_lsu_master #(.DEPTH_WORDS(DEPTH), .ADDR_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_pc     (req_pc),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_we      (dm_we),
    .dm_pc      (dm_pc),
    .dm_rdata   (dm_rdata)
  );

  // Behavioural memory: combinational read, posedge write.
  assign rd_idx   = int'(dm_addr >> 2);
  assign dm_rdata = (dm_addr < DEPTH * 4) ? mem[rd_idx] : 32'h0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (dm_we && (dm_addr < DEPTH * 4)) mem[rd_idx] <= dm_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every response must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && resp_valid) begin
      if (exp_q.size() == 0) begin
        check("resp_unexpected", {31'b0, resp_valid}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("resp_data", resp_data, e.data);
        check("resp_err", {31'b0, resp_err}, {31'b0, e.err});
      end
    end
  end

  task automatic preload(input int idx, input logic [31:0] val);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_idx = idx; pl_data = val;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Single-cycle request (loads, sw, error cases). Called at posedge+1.
  task automatic single(input string name, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_data,
                        input logic exp_err, input logic exp_we);
    exp_t e;
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata; req_pc = 32'h0000_4000 + addr;
    e.data = exp_data; e.err = exp_err;
    exp_q.push_back(e);
    @(negedge clk);
    check({name, "_ready"}, {31'b0, req_ready}, 32'd1);
    check({name, "_we"}, {31'b0, dm_we}, {31'b0, exp_we});
    check({name, "_addr"}, dm_addr, addr & 32'hFFFF_FFFC);
    check({name, "_pc"}, dm_pc, 32'h0000_4000 + addr);
    if (exp_we) check({name, "_wdata"}, dm_wdata, wdata);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Sub-word store via RMW; abort asserts reset during RMW_WR.
  task automatic rmw(input string name, input logic [2:0] op, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_merge, input logic abort);
    exp_t e;
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata; req_pc = 32'hCAFE_0000;
    if (!abort) begin
      e.data = 32'h0; e.err = 1'b0;
      exp_q.push_back(e);
    end
    @(negedge clk);                                   // T
    check({name, "_T_ready"}, {31'b0, req_ready}, 32'd1);
    check({name, "_T_we"}, {31'b0, dm_we}, 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0; req_pc = 32'h0; req_addr = 32'h0;
    @(negedge clk);                                   // T+1
    check({name, "_T1_ready"}, {31'b0, req_ready}, 32'd0);
    check({name, "_T1_we"}, {31'b0, dm_we}, 32'd0);
    check({name, "_T1_addr"}, dm_addr, addr & 32'hFFFF_FFFC);
    check({name, "_T1_pc"}, dm_pc, 32'hCAFE_0000);
    @(posedge clk); #1;
    if (abort) reset = 1'b1;
    @(negedge clk);                                   // T+2
    check({name, "_T2_ready"}, {31'b0, req_ready}, 32'd0);
    check({name, "_T2_we"}, {31'b0, dm_we}, {31'b0, !abort});
    if (!abort) check({name, "_T2_wdata"}, dm_wdata, exp_merge);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);                                   // T+3
    check({name, "_T3_ready"}, {31'b0, req_ready}, 32'd1);
    check({name, "_T3_we"}, {31'b0, dm_we}, 32'd0);
    if (abort) check({name, "_T3_noresp"}, {31'b0, resp_valid}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    preload(4, 32'h8899_AABB);      // 0x10
    preload(5, 32'h1122_3344);      // 0x14
    preload(8, 32'h0000_0000);      // 0x20
    preload(DEPTH - 1, 32'hA5A5_0F0F);
    req_valid = 1'b1; req_op = OP_SW;
    @(negedge clk);
    check("reset_ready", {31'b0, req_ready}, 32'd1);
    check("reset_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("reset_resp_data", resp_data, 32'd0);
    check("reset_resp_err", {31'b0, resp_err}, 32'd0);
    check("reset_we", {31'b0, dm_we}, 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0; reset = 1'b0;

    // Sub-word loads, back to back.
    single("lb11",  OP_LB,  32'h11, 32'h0, 32'hFFFF_FFAA, 1'b0, 1'b0);
    single("lbu11", OP_LBU, 32'h11, 32'h0, 32'h0000_00AA, 1'b0, 1'b0);
    single("lh12",  OP_LH,  32'h12, 32'h0, 32'hFFFF_8899, 1'b0, 1'b0);
    single("lhu12", OP_LHU, 32'h12, 32'h0, 32'h0000_8899, 1'b0, 1'b0);
    single("lb10",  OP_LB,  32'h10, 32'h0, 32'hFFFF_FFBB, 1'b0, 1'b0);
    single("lbu13", OP_LBU, 32'h13, 32'h0, 32'h0000_0088, 1'b0, 1'b0);
    single("lh10",  OP_LH,  32'h10, 32'h0, 32'hFFFF_AABB, 1'b0, 1'b0);
    single("lw10",  OP_LW,  32'h10, 32'h0, 32'h8899_AABB, 1'b0, 1'b0);

    // sb RMW, then read back.
    rmw("sb13", OP_SB, 32'h13, 32'h0000_00CC, 32'hCC99_AABB, 1'b0);
    single("lw10b", OP_LW, 32'h10, 32'h0, 32'hCC99_AABB, 1'b0, 1'b0);

    // sw then lw.
    single("sw20", OP_SW, 32'h20, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1);
    single("lw20", OP_LW, 32'h20, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);

    // sh lower half, then sh upper half abandoned by reset.
    rmw("sh14", OP_SH, 32'h14, 32'hFFFF_5678, 32'h1122_5678, 1'b0);
    rmw("sh16_abort", OP_SH, 32'h16, 32'h0000_1234, 32'h0, 1'b1);
    check("sh16_mem_unchanged", mem[5], 32'h1122_5678);
    single("lw14", OP_LW, 32'h14, 32'h0, 32'h1122_5678, 1'b0, 1'b0);

    // Range boundary.
    single("lw_last", OP_LW, 32'h2FFC, 32'h0, 32'hA5A5_0F0F, 1'b0, 1'b0);
    single("lw_oor",  OP_LW, 32'h3000, 32'h0, 32'h0, 1'b1, 1'b0);
    single("sw_oor",  OP_SW, 32'h3000, 32'h1234_5678, 32'h0, 1'b1, 1'b0);
    single("sb_oor",  OP_SB, 32'h3001, 32'h0000_0055, 32'h0, 1'b1, 1'b0);

    // Misaligned accesses.
`ifdef DM_LSU_MISALIGN_TRAP_EN
    single("lw22", OP_LW, 32'h22, 32'h0, 32'h0, 1'b1, 1'b0);
    single("lh13", OP_LH, 32'h13, 32'h0, 32'h0, 1'b1, 1'b0);
    single("sw21", OP_SW, 32'h21, 32'h0BAD_0BAD, 32'h0, 1'b1, 1'b0);
    single("lw20c", OP_LW, 32'h20, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);
`else
    single("lw22", OP_LW, 32'h22, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    single("lh13", OP_LH, 32'h13, 32'h0, 32'hFFFF_CC99, 1'b0, 1'b0);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dm_lsu_master.md
Name: dm_lsu_master

Overview:
- Load/store unit in the MEM stage; acts as the initiator towards the word-wide data memory.
- The memory provides a combinational word read, a posedge word write with a single write enable, and no byte enables.
- Block supports lw/lh/lhu/lb/lbu/sw/sh/sb; sub-word stores are done as a registered read-modify-write sequence.
- Pipeline stalls on req_ready low.

Parameters:
- DEPTH_WORDS, 3072, number of 32-bit words addressable; byte addresses >= DEPTH_WORDS*4 are out of range.
- ADDR_W, 32, request and memory address width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  access request from the pipeline
- req_ready  out  1  high when IDLE; request accepted on req_valid & req_ready
- req_op  in  3  0 lw, 1 lh, 2 lhu, 3 lb, 4 lbu, 5 sw, 6 sh, 7 sb
- req_addr  in  32  byte address
- req_wdata  in  32  store data; low byte or halfword used for sb/sh
- req_pc  in  32  PC of the instruction, forwarded to the memory
- resp_valid  out  1  one-cycle completion pulse
- resp_data  out  32  load result, extended per op; 0 for stores
- resp_err  out  1  address error, valid with resp_valid
- dm_addr  out  32  word-aligned address to the memory (low 2 bits are 0)
- dm_wdata  out  32  word to write
- dm_we  out  1  memory write enable
- dm_pc  out  32  PC forwarded to the memory
- dm_rdata  in  32  combinational read word from the memory

Behaviour:
- Reset: state IDLE; resp_valid=0, resp_data=0, resp_err=0, dm_we=0; all internal latches cleared.
- States:
  - IDLE: req_ready=1.
  - RMW_RD: req_ready=0.
  - RMW_WR: req_ready=0.
- Load, accepted in cycle T:
  - dm_addr = {req_addr[31:2],2'b00} in T.
  - Byte/halfword lane selected by addr[1:0]: little-endian, byte k = bits 8k+7:8k.
  - Sign-extend for lh/lb, zero-extend for lhu/lbu.
  - Result registered; resp_valid=1 in T+1.
- sw, accepted in T: dm_we=1 and dm_wdata=req_wdata in T; resp_valid in T+1.
- sh/sb, accepted in T:
  - Latch op, addr, wdata, pc; go to RMW_RD.
  - T+1 (RMW_RD): dm_addr = latched word address; capture dm_rdata into merge register with the target lane replaced; go to RMW_WR.
  - T+2 (RMW_WR): dm_we=1, dm_wdata = merge register; go to IDLE.
  - resp_valid in T+3; next request can be accepted in T+3.
- dm_we is asserted only in a sw accept cycle or in RMW_WR, and is forced 0 while reset=1.
- dm_pc = req_pc in IDLE and the latched pc in the RMW states.
- Out of range (addr >= DEPTH_WORDS*4):
  - No dm_we and no RMW sequence.
  - resp_valid in T+1 with resp_err=1 and resp_data=0.
- Misaligned access (word with addr[1:0]!=0, halfword with addr[0]=1): see Optional Feature.
- req_valid while busy is ignored. The requester holds the request until it is accepted.
- Reset in RMW_RD or RMW_WR: the sequence is abandoned, no write and no resp_valid, next state IDLE.
- resp_valid is a single-cycle pulse; no back-pressure on the response.

Optional Feature:
- Macro: DM_LSU_MISALIGN_TRAP_EN.
- Defined: a misaligned access performs no memory write and no RMW sequence; resp_valid in T+1 with resp_err=1 and resp_data=0.
- Undefined: misaligned addresses are silently aligned. Word ops ignore addr[1:0]; halfword ops ignore addr[0]. resp_err is raised only for out-of-range addresses.

Decomposition:
- Package dm_lsu_pkg:
  - op code constants (OP_LW..OP_SB);
  - state enum (IDLE, RMW_RD, RMW_WR);
  - helpers is_load, is_store, access_size.
- Sub-module dm_lsu_lane: combinational lane extract with sign/zero extension for loads, and lane merge for sub-word stores.
- The FSM and registers stay in dm_lsu_master.

Test Plan:
- Memory word 0x10 = 0x8899AABB; lb 0x11 -> resp_data 0xFFFFFFAA in T+1; lbu 0x11 -> 0x000000AA; lh 0x12 -> 0xFFFF8899; lhu 0x12 -> 0x00008899.
- sb 0x13 with wdata 0x000000CC onto 0x8899AABB -> dm_we only in T+2 with dm_wdata 0xCC99AABB; req_ready low in T+1 and T+2; resp_valid in T+3.
- sw 0x20 with 0xDEADBEEF -> dm_we=1 in T; a following lw 0x20 returns 0xDEADBEEF.
- sh 0x16 with 0x1234 and reset asserted in T+2 -> no dm_we, no resp_valid, req_ready=1 after reset, memory word unchanged.
- lw 0x3000 with DEPTH_WORDS=3072 -> resp_err=1, resp_data=0, no dm_we.
- lw 0x22 -> with DM_LSU_MISALIGN_TRAP_EN: resp_err=1; without it: returns the word at 0x20 with resp_err=0.
